// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer that borrows the shared ALU adder.
// Produces the low WIDTH bits of op_a * op_b in 1..WIDTH RUN cycles.
module alu_mul_seq #(
    parameter int          WIDTH   = 32,
    parameter logic [3:0]  ALU_ADD = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [4:0]       count;
    logic             last;

    // Stop early once no multiplier bits remain, so k tracks op_b's top bit.
    always_comb begin
        acc_next   = mplier[0] ? alu_result : acc;
        last       = ((mplier >> 1) == '0) || (count == 5'd31);
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_a    = acc;
        alu_b    = (state == RUN) ? mcand : '0;
        alu_ctrl = ALU_ADD;
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == RUN) && last;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                    if (last) result <= acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule
